// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction phase sequencer.
// States, light encodings and default phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    WALK  = 3'd6,
    EMERG = 3'd7
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam int T_GREEN_DEF  = 9;
  localparam int T_YELLOW_DEF = 3;
  localparam int T_ALLRED_DEF = 1;
  localparam int T_WALK_DEF   = 7;

endpackage

// File: rtl/traffic_phase_ctrl.sv
// Two-road junction phase sequencer driving the countdown timer,
// vehicle lights, pedestrian walk lamp and emergency all-red.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN  = T_GREEN_DEF,
  parameter int T_YELLOW = T_YELLOW_DEF,
  parameter int T_ALLRED = T_ALLRED_DEF,
  parameter int T_WALK   = T_WALK_DEF
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       timer_exp,
  input  logic       ped_req,
  input  logic       emerg,
  output logic       st_timer,
  output logic [3:0] time_val,
  output logic       timer_clr,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [3:0] TV_G  = 4'(T_GREEN);
  localparam logic [3:0] TV_Y  = 4'(T_YELLOW);
  localparam logic [3:0] TV_AR = 4'(T_ALLRED);
  localparam logic [3:0] TV_W  = 4'(T_WALK);

  state_t     state;
  state_t     nxt_state;
  dir_t       next_dir;
  dir_t       nxt_dir;
  logic       ped_pending;
  logic       nxt_pend;
  logic       clr_n;
  logic [3:0] tv_n;
  logic [2:0] ns_n;
  logic [2:0] ew_n;
  logic       walk_n;

  always_comb begin
    nxt_state = state;
    nxt_dir   = next_dir;
    clr_n     = 1'b0;
    if (state == EMERG) begin
      if (!emerg) begin
        nxt_state = AR_NS;
        nxt_dir   = DIR_NS;
        clr_n     = 1'b1;
      end
    end else if (emerg) begin
      nxt_state = EMERG;
      clr_n     = 1'b1;
    end else if (timer_exp) begin
      unique case (1'b1)
        (state == AR_NS): nxt_state = NS_G;
        (state == NS_G):  nxt_state = NS_Y;
        (state == AR_EW): nxt_state = EW_G;
        (state == EW_G):  nxt_state = EW_Y;
        (state == NS_Y): begin
          nxt_state = ped_pending ? WALK : AR_EW;
          nxt_dir   = DIR_EW;
        end
        (state == EW_Y): begin
          nxt_state = ped_pending ? WALK : AR_NS;
          nxt_dir   = DIR_NS;
        end
        (state == WALK):
          nxt_state = (next_dir == DIR_EW) ? AR_EW : AR_NS;
        default: nxt_state = state;
      endcase
    end
  end

  // Entering WALK serves the request, including one arriving that cycle.
  always_comb begin
    nxt_pend = ped_pending;
    if (state != WALK && nxt_state == WALK)
      nxt_pend = 1'b0;
    else if (ped_req && state != WALK)
      nxt_pend = 1'b1;
  end

  always_comb begin
    tv_n   = TV_AR;
    ns_n   = LT_RED;
    ew_n   = LT_RED;
    walk_n = 1'b0;
    unique case (1'b1)
      (nxt_state == NS_G): begin
        tv_n = TV_G;
        ns_n = LT_GRN;
      end
      (nxt_state == NS_Y): begin
        tv_n = TV_Y;
        ns_n = LT_YEL;
      end
      (nxt_state == EW_G): begin
        tv_n = TV_G;
        ew_n = LT_GRN;
      end
      (nxt_state == EW_Y): begin
        tv_n = TV_Y;
        ew_n = LT_YEL;
      end
      (nxt_state == WALK): begin
        tv_n   = TV_W;
        walk_n = 1'b1;
      end
      (nxt_state == EMERG): tv_n = 4'd0;
      default: tv_n = TV_AR;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= AR_NS;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
      st_timer    <= 1'b0;
      timer_clr   <= 1'b0;
      time_val    <= TV_AR;
      ns_light    <= LT_RED;
      ew_light    <= LT_RED;
      walk        <= 1'b0;
    end else begin
      state       <= nxt_state;
      next_dir    <= nxt_dir;
      ped_pending <= nxt_pend;
      st_timer    <= (nxt_state != EMERG);
      timer_clr   <= clr_n;
      time_val    <= tv_n;
      ns_light    <= ns_n;
      ew_light    <= ew_n;
      walk        <= walk_n;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus random
// stimulus against a table-driven reference model.
module tb_traffic_phase_ctrl;

  localparam int TG = 9;
  localparam int TY = 3;
  localparam int TA = 1;
  localparam int TW = 7;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       timer_exp = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic       st_timer;
  logic [3:0] time_val;
  logic       timer_clr;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  traffic_phase_ctrl #(
    .T_GREEN (TG),
    .T_YELLOW(TY),
    .T_ALLRED(TA),
    .T_WALK  (TW)
  ) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .timer_exp(timer_exp),
    .ped_req  (ped_req),
    .emerg    (emerg),
    .st_timer (st_timer),
    .time_val (time_val),
    .timer_clr(timer_clr),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: phase numbers with lookup tables.
  int dur[8]    = '{TA, TG, TY, TA, TG, TY, TW, 0};
  int ns_tab[8] = '{4, 1, 2, 4, 4, 4, 4, 4};
  int ew_tab[8] = '{4, 4, 4, 4, 1, 2, 4, 4};
  int succ[8]   = '{1, 2, 3, 4, 5, 0, 0, 7};
  int m_ph = 0;
  int m_st = 0;
  int m_clr = 0;
  int m_pend = 0;
  int m_dir_ew = 0;

  task automatic model_update(input logic te, pr, em, rs);
    int old_ph;
    old_ph = m_ph;
    m_clr = 0;
    if (rs) begin
      m_ph = 0;
      m_st = 0;
      m_pend = 0;
      m_dir_ew = 0;
      return;
    end
    if (old_ph == 7) begin
      if (!em) begin
        m_ph = 0;
        m_dir_ew = 0;
        m_clr = 1;
      end
    end else if (em) begin
      m_ph = 7;
      m_clr = 1;
    end else if (te) begin
      if (old_ph == 2 || old_ph == 5) begin
        m_ph = m_pend ? 6 : succ[old_ph];
        m_dir_ew = (old_ph == 2) ? 1 : 0;
      end else if (old_ph == 6) begin
        m_ph = m_dir_ew ? 3 : 0;
      end else begin
        m_ph = succ[old_ph];
      end
    end
    if (m_ph == 6 && old_ph != 6) m_pend = 0;
    else if (pr && old_ph != 6) m_pend = 1;
    m_st = (m_ph != 7) ? 1 : 0;
  endtask

  task automatic step(input logic te, pr, em, rs);
    timer_exp = te;
    ped_req = pr;
    emerg = em;
    reset = rs;
    @(posedge sys_clk);
    model_update(te, pr, em, rs);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic adv(input int n, input logic pr);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) step(1'b0, pr, 1'b0, 1'b0);
      step(1'b1, pr, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({phase, time_val, st_timer, timer_clr, ns_light, ew_light, walk}
        !== {3'd0, 4'd1, 1'b0, 1'b0, 3'b100, 3'b100, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals: got ph=%0d tv=%0d st=%b clr=%b ns=%b ew=%b w=%b",
               phase, time_val, st_timer, timer_clr, ns_light, ew_light, walk);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (st_timer !== 1'b1 || phase !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: st=%b ph=%0d want st=1 ph=0", st_timer, phase);
    end
  endtask

  task automatic test_cycle();
    int exp_ph[6] = '{1, 2, 3, 4, 5, 0};
    int exp_tv[6] = '{9, 3, 1, 9, 3, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 19; k++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (st_timer !== 1'b1) begin
          failures++;
          $display("FAIL cycle_st: st=%b want 1", st_timer);
        end
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (phase !== 3'(exp_ph[i]) || time_val !== 4'(exp_tv[i])
          || st_timer !== 1'b1) begin
        failures++;
        $display("FAIL cycle_%0d: ph=%0d tv=%0d st=%b want ph=%0d tv=%0d st=1",
                 i, phase, time_val, st_timer, exp_ph[i], exp_tv[i]);
      end
    end
  endtask

  task automatic test_ped();
    do_reset();
    adv(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    adv(1, 1'b0);
    adv(1, 1'b0);
    checks++;
    if ({phase, walk, time_val, ns_light, ew_light}
        !== {3'd6, 1'b1, 4'd7, 3'b100, 3'b100}) begin
      failures++;
      $display("FAIL ped_walk: ph=%0d w=%b tv=%0d ns=%b ew=%b want 6 1 7 100 100",
               phase, walk, time_val, ns_light, ew_light);
    end
    adv(1, 1'b0);
    checks++;
    if (phase !== 3'd3 || walk !== 1'b0) begin
      failures++;
      $display("FAIL ped_exit: ph=%0d w=%b want ph=3 w=0", phase, walk);
    end
  endtask

  task automatic test_ped_hold();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    adv(2, 1'b0);
    adv(1, 1'b1);
    checks++;
    if (phase !== 3'd6) begin
      failures++;
      $display("FAIL hold_enter: ph=%0d want 6", phase);
    end
    adv(1, 1'b1);
    checks++;
    if (phase !== 3'd3) begin
      failures++;
      $display("FAIL hold_exit: ph=%0d want 3", phase);
    end
    adv(3, 1'b0);
    checks++;
    if (phase !== 3'd0 || walk !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_pend: ph=%0d w=%b want ph=0 w=0", phase, walk);
    end
  endtask

  task automatic test_emerg();
    do_reset();
    adv(4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({phase, ns_light, ew_light, st_timer, timer_clr, time_val}
        !== {3'd7, 3'b100, 3'b100, 1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL emerg_enter: ph=%0d ns=%b ew=%b st=%b clr=%b tv=%0d",
               phase, ns_light, ew_light, st_timer, timer_clr, time_val);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (phase !== 3'd7 || timer_clr !== 1'b0 || st_timer !== 1'b0) begin
      failures++;
      $display("FAIL emerg_hold: ph=%0d clr=%b st=%b want 7 0 0",
               phase, timer_clr, st_timer);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({phase, time_val, st_timer, timer_clr} !== {3'd0, 4'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL emerg_exit: ph=%0d tv=%0d st=%b clr=%b want 0 1 1 1",
               phase, time_val, st_timer, timer_clr);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timer_clr !== 1'b0 || phase !== 3'd0) begin
      failures++;
      $display("FAIL emerg_clr_once: clr=%b ph=%0d want 0 0", timer_clr, phase);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    adv(2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (phase !== 3'd7 || timer_clr !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle: ph=%0d clr=%b want 7 1", phase, timer_clr);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (phase !== 3'd0 || time_val !== 4'd1 || timer_clr !== 1'b1) begin
      failures++;
      $display("FAIL same_fall: ph=%0d tv=%0d clr=%b want 0 1 1",
               phase, time_val, timer_clr);
    end
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    adv(3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({phase, time_val, st_timer, timer_clr, ns_light, ew_light, walk}
        !== {3'd0, 4'd1, 1'b0, 1'b0, 3'b100, 3'b100, 1'b0}) begin
      failures++;
      $display("FAIL reset_in_walk: ph=%0d tv=%0d st=%b clr=%b ns=%b ew=%b w=%b",
               phase, time_val, st_timer, timer_clr, ns_light, ew_light, walk);
    end
  endtask

  task automatic test_random();
    logic [17:0] got;
    logic [17:0] want;
    logic te, pr, em, rs;
    int bad = 0;
    do_reset();
    em = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      te = ($urandom_range(0, 3) == 0);
      pr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) em = ~em;
      rs = ($urandom_range(0, 499) == 0);
      step(te, pr, em, rs);
      got = {phase, time_val, st_timer, timer_clr, ns_light, ew_light, walk};
      want = {3'(m_ph), (rs ? 4'(TA) : 4'(dur[m_ph])), 1'(m_st), 1'(m_clr),
              3'(ns_tab[m_ph]), 3'(ew_tab[m_ph]), 1'(m_ph == 6)};
      checks++;
      if (got !== want) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_%0d: got=%h want=%h", i, got, want);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_ped();
    test_ped_hold();
    test_emerg();
    test_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase sequencer for a two-road (NS/EW) junction. It drives the countdown timer block: it issues `st_timer`, `time_val` and `timer_clr`, and advances one phase on each `timer_exp` pulse. It also drives the vehicle lights and the pedestrian walk lamp, serves latched pedestrian requests and forces all-red on an emergency input.

## Interface
- `T_GREEN`, default 9: green duration in ticks (1..15).
- `T_YELLOW`, default 3: yellow duration in ticks (1..15).
- `T_ALLRED`, default 1: all-red clearance duration in ticks (1..15).
- `T_WALK`, default 7: pedestrian walk duration in ticks (1..15).
- `sys_clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `timer_exp`  in  1  single-cycle expiry pulse from the timer.
- `ped_req`  in  1  pedestrian button, pulse or level, sampled each cycle.
- `emerg`  in  1  emergency override, level.
- `st_timer`  out  1  timer run enable.
- `time_val`  out  4  duration of the current phase.
- `timer_clr`  out  1  one-cycle timer clear pulse, wired to the timer's `repro` input.
- `ns_light`  out  3  {red, yellow, green}, one-hot.
- `ew_light`  out  3  {red, yellow, green}, one-hot.
- `walk`  out  1  pedestrian walk lamp.
- `phase`  out  3  current state code, for display and debug.

## Operation
- States and codes:
  - AR_NS=0, NS_G=1, NS_Y=2, AR_EW=3, EW_G=4, EW_Y=5, WALK=6, EMERG=7.
- Transitions on `timer_exp`=1, when not in EMERG:
  - AR_NS→NS_G, NS_G→NS_Y, AR_EW→EW_G, EW_G→EW_Y.
  - NS_Y→WALK if `ped_pending`, else AR_EW.
  - EW_Y→WALK if `ped_pending`, else AR_NS.
  - WALK→AR_EW if `next_dir`=EW, else AR_NS.
  - `next_dir` is registered on leaving NS_Y (set to EW) or EW_Y (set to NS).
- `time_val` per state:
  - AR_* = T_ALLRED, *_G = T_GREEN, *_Y = T_YELLOW, WALK = T_WALK.
  - EMERG drives 0.
  - The new value is loaded on the same edge as the state change.
- Lights:
  - Active road shows G or Y; the other road is red.
  - AR_*, WALK and EMERG show both roads red.
  - `walk`=1 only in WALK.
- `st_timer`:
  - 1 in every state except EMERG.
  - Held high across phase changes; the timer restarts itself after expiry.
- `ped_pending`:
  - Set by `ped_req`=1 in any state except WALK.
  - Cleared on the edge entering WALK; a request in that same cycle is absorbed by this walk.
  - `ped_req` during WALK is ignored.
- `emerg` has highest priority:
  - When `emerg`=1 in any non-EMERG state, the next state is EMERG, `st_timer`→0 and `timer_clr`=1 for exactly one cycle.
  - While in EMERG, `timer_exp` is ignored.
  - When `emerg` falls, the next state is AR_NS with `time_val`=T_ALLRED, `st_timer`=1, `timer_clr`=1 for one cycle, and `next_dir` reset to NS.
  - `ped_pending` is retained through EMERG.

## Timing
- All outputs are registered.
- Reset values:
  - state AR_NS, `time_val`=T_ALLRED, `st_timer`=0, `timer_clr`=0.
  - `ns_light`=`ew_light`=3'b100, `walk`=0, `phase`=0.
  - `ped_pending`=0, `next_dir`=NS.
- The first cycle after reset deasserts drives `st_timer`=1.
- Phase latency: `timer_exp` sampled high at edge N changes state, lights, `time_val` and `phase` at edge N, visible from cycle N+1.
- Each phase lasts `time_val` ticks of the timer plus at most one `sys_clk`.
- Simultaneous `timer_exp` and `emerg` rising: EMERG wins and the phase advance is discarded.
- Simultaneous `timer_exp` and `emerg` falling: exit to AR_NS as defined above.
- `reset` mid-phase returns to the reset values on the next edge, regardless of `emerg`.
- Lights never show a direct green-to-red or green-to-green change between roads. Every road switch passes through Y, then AR_* or WALK.

## Structure
- Shared package `traffic_pkg`:
  - state enum/codes,
  - light encodings `LT_RED`=3'b100, `LT_YEL`=3'b010, `LT_GRN`=3'b001,
  - default durations.
- Single module, no sub-modules. One next-state/output decode block plus registers for `state`, `ped_pending` and `next_dir`.
- Top-level integration pairs this block with the existing timer block.

## Test plan
- Reset, then `timer_exp` pulse every 20 cycles, no requests:
  - `phase` sequence 0,1,2,3,4,5,0.
  - `time_val` sequence 1,9,3,1,9,3.
  - `st_timer` stays 1 throughout.
- `ped_req` pulse during NS_G, then expiry in NS_Y:
  - next `phase`=6, `walk`=1, `time_val`=7, both lights 3'b100.
  - after the next expiry, `phase`=3.
- `ped_req` held high throughout WALK: on leaving WALK, `ped_pending` stays 0.
- `emerg`=1 during EW_G:
  - next cycle: `phase`=7, both lights red, `st_timer`=0, `timer_clr` pulses exactly one cycle.
  - `timer_exp` pulses are ignored while in EMERG.
- `emerg` falls:
  - next cycle: `phase`=0, `time_val`=1, `st_timer`=1, `timer_clr`=1 for one cycle.
- Same-cycle `timer_exp`+`emerg` rise in NS_Y, and `reset` asserted in WALK:
  - first case: `phase`=7.
  - second case: all reset values next cycle.
